sram_controller: RTL and testbench

Memory-stage controller between the EXE/MEM pipeline register and an off-chip 16-bit asynchronous SRAM. It accepts the execute stage's memory request: `mem_r_en`/`mem_w_en`, the ALU result as the byte address, and `val_rm` as the store data. Each 32-bit word access is split into two 16-bit SRAM transactions followed by a fixed settle wait. `ready` is deasserted for the duration so the hazard/freeze logic stalls the pipeline until the access completes.

---
 rtl/arm_pkg.sv | 18 +
 rtl/sram_controller.sv | 131 +++++++++++++
 tb/tb_sram_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the memory stage: SRAM geometry, default mapping and
// the controller state encoding.
package arm_pkg;

  localparam int unsigned SRAM_ADDR_W    = 18;
  localparam int unsigned SRAM_DATA_W    = 16;
  localparam int unsigned SRAM_WORD_W    = 17;
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

  typedef enum logic [2:0] {
    SRAM_IDLE,
    SRAM_LO,
    SRAM_HI,
    SRAM_WAIT,
    SRAM_DONE
  } sram_state_e;

endpackage

// File: rtl/sram_controller.sv
// Memory-stage controller: splits each 32-bit load/store into two 16-bit
// SRAM transactions plus a settle wait, holding ready low until done.
module sram_controller
  import arm_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  sram_state_e            r_state;
  sram_state_e            w_next;
  logic                   r_is_write;
  logic [SRAM_WORD_W-1:0] r_word;
  logic [15:0]            r_wdata_hi;
  logic [15:0]            r_rdata_lo;
  logic [15:0]            r_rdata_hi;
  logic [3:0]             r_cnt;
  logic [31:0]            r_read_data;
  logic [SRAM_ADDR_W-1:0] r_addr;
  logic [SRAM_DATA_W-1:0] r_dq_out;
  logic                   r_oe;
  logic                   r_we_n;

  logic                   w_req;
  logic [SRAM_WORD_W-1:0] w_req_word;
  logic [SRAM_ADDR_W-1:0] w_addr_d;
  logic [SRAM_DATA_W-1:0] w_dq_d;
  logic                   w_oe_d;
  logic                   w_we_n_d;

  assign w_req      = mem_r_en | mem_w_en;
  assign w_req_word = SRAM_WORD_W'((address - BASE_ADDR) >> 2);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SRAM_IDLE: if (w_req) w_next = SRAM_LO;
      SRAM_LO:   w_next = SRAM_HI;
      SRAM_HI:   w_next = (WAIT_CYCLES == 0) ? SRAM_DONE : SRAM_WAIT;
      SRAM_WAIT: if (r_cnt == 4'd0) w_next = SRAM_DONE;
      SRAM_DONE: w_next = SRAM_IDLE;
      default:   w_next = SRAM_IDLE;
    endcase
  end

  // Bus outputs are registered, so the values for the next state are prepared
  // here; entering LO uses the live inputs because the latch happens on that same edge.
  always_comb begin
    w_addr_d = r_addr;
    w_dq_d   = r_dq_out;
    w_oe_d   = 1'b0;
    w_we_n_d = 1'b1;
    if (w_next == SRAM_LO) begin
      w_addr_d = {w_req_word, 1'b0};
      w_dq_d   = write_data[15:0];
      w_oe_d   = mem_w_en;
      w_we_n_d = ~mem_w_en;
    end else if (w_next == SRAM_HI) begin
      w_addr_d = {r_word, 1'b1};
      w_dq_d   = r_wdata_hi;
      w_oe_d   = r_is_write;
      w_we_n_d = ~r_is_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SRAM_IDLE;
      r_is_write  <= 1'b0;
      r_word      <= '0;
      r_wdata_hi  <= '0;
      r_rdata_lo  <= '0;
      r_rdata_hi  <= '0;
      r_cnt       <= '0;
      r_read_data <= '0;
      r_addr      <= '0;
      r_dq_out    <= '0;
      r_oe        <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_addr   <= w_addr_d;
      r_dq_out <= w_dq_d;
      r_oe     <= w_oe_d;
      r_we_n   <= w_we_n_d;

      if (r_state == SRAM_IDLE && w_req) begin
        r_is_write <= mem_w_en;
        r_word     <= w_req_word;
        r_wdata_hi <= write_data[31:16];
      end

      if (r_state == SRAM_LO && !r_is_write) r_rdata_lo <= sram_dq_in;
      if (r_state == SRAM_HI && !r_is_write) r_rdata_hi <= sram_dq_in;

      if (r_state == SRAM_HI)
        r_cnt <= WAIT_LOAD;
      else if (r_state == SRAM_WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;

      // With no wait states the high half arrives on the same edge that enters DONE.
      if (w_next == SRAM_DONE && r_state != SRAM_DONE && !r_is_write)
        r_read_data <= (r_state == SRAM_HI) ? {sram_dq_in, r_rdata_lo}
                                            : {r_rdata_hi, r_rdata_lo};
    end
  end

  assign ready       = (r_state == SRAM_IDLE && !w_req) || (r_state == SRAM_DONE);
  assign read_data   = r_read_data;
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_oe;
  assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: default-wait instance against a small
// SRAM model, plus a zero-wait instance reading a fixed bus value.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_en = 1'b0, w_en = 1'b0, r1_en = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1;
  logic [17:0] saddr0, saddr1;
  logic [15:0] dqo0, dqo1, dqi0;
  logic        oe0, oe1, wen0, wen1;

  logic [15:0] mem [0:63];
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en),
    .address(addr), .write_data(wdata), .read_data(rdata0), .ready(ready0),
    .sram_addr(saddr0), .sram_dq_out(dqo0), .sram_dq_oe(oe0),
    .sram_dq_in(dqi0), .sram_we_n(wen0)
  );

  sram_controller #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) dut0w (
    .clk(clk), .rst(rst), .mem_r_en(r1_en), .mem_w_en(1'b0),
    .address(addr), .write_data(wdata), .read_data(rdata1), .ready(ready1),
    .sram_addr(saddr1), .sram_dq_out(dqo1), .sram_dq_oe(oe1),
    .sram_dq_in(16'hA5C3), .sram_we_n(wen1)
  );

  initial for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  always @(posedge clk) if (!wen0) mem[saddr0[5:0]] <= dqo0;
  assign dqi0 = mem[saddr0[5:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    cyc();
    chk("rst_ready", ready0, 1);
    chk("rst_we_n", wen0, 1);
    chk("rst_oe", oe0, 0);
    chk("rst_addr", saddr0, 0);
    chk("rst_rdata", rdata0, 0);
    chk("rst_ready_w0", ready1, 1);
    rst = 1'b0;

    // Idle, no request
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("idle_ready", ready0, 1);
      chk("idle_we_n", wen0, 1);
      chk("idle_oe", oe0, 0);
    end

    // Store 0xDEADBEEF to 1028
    addr = 32'd1028; wdata = 32'hDEADBEEF; w_en = 1'b1;
    #1 chk("st_c0_ready", ready0, 0);
    cyc();
    chk("st_c1_addr", saddr0, 2);
    chk("st_c1_dq", dqo0, 32'hBEEF);
    chk("st_c1_we_n", wen0, 0);
    chk("st_c1_oe", oe0, 1);
    chk("st_c1_ready", ready0, 0);
    cyc();
    chk("st_c2_addr", saddr0, 3);
    chk("st_c2_dq", dqo0, 32'hDEAD);
    chk("st_c2_we_n", wen0, 0);
    for (int c = 3; c <= 5; c++) begin
      cyc();
      chk("st_wait_ready", ready0, 0);
      chk("st_wait_we_n", wen0, 1);
      chk("st_wait_oe", oe0, 0);
      chk("st_wait_addr", saddr0, 3);
    end
    cyc();
    chk("st_c6_ready", ready0, 1);
    chk("st_c6_rdata", rdata0, 0);
    w_en = 1'b0;
    cyc();
    chk("st_after_ready", ready0, 1);
    chk("st_mem_lo", {16'h0, mem[2]}, 32'hBEEF);
    chk("st_mem_hi", {16'h0, mem[3]}, 32'hDEAD);

    // Load from 1028
    r_en = 1'b1;
    #1 chk("ld_c0_ready", ready0, 0);
    cyc();
    chk("ld_c1_addr", saddr0, 2);
    chk("ld_c1_we_n", wen0, 1);
    chk("ld_c1_oe", oe0, 0);
    cyc();
    chk("ld_c2_addr", saddr0, 3);
    chk("ld_c2_we_n", wen0, 1);
    for (int c = 3; c <= 5; c++) begin
      cyc();
      chk("ld_wait_ready", ready0, 0);
      chk("ld_wait_we_n", wen0, 1);
    end
    cyc();
    chk("ld_c6_ready", ready0, 1);
    chk("ld_c6_rdata", rdata0, 32'hDEADBEEF);
    chk("ld_c6_we_n", wen0, 1);
    r_en = 1'b0;
    cyc();

    // Reset during the high half of a store
    addr = 32'd1036; wdata = 32'h11112222; w_en = 1'b1;
    cyc();
    chk("ab_c1_we_n", wen0, 0);
    cyc();
    chk("ab_c2_we_n", wen0, 0);
    chk("ab_c2_addr", saddr0, 7);
    w_en = 1'b0; rst = 1'b1;
    #1;
    chk("ab_we_n", wen0, 1);
    chk("ab_oe", oe0, 0);
    chk("ab_ready", ready0, 1);
    chk("ab_addr", saddr0, 0);
    chk("ab_rdata", rdata0, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("ab_idle_ready", ready0, 1);

    // Back-to-back store then load at 1024, request held across DONE
    addr = 32'd1024; wdata = 32'hCAFEF00D; w_en = 1'b1;
    cyc();
    chk("bb_c1_addr", saddr0, 0);
    chk("bb_c1_dq", dqo0, 32'hF00D);
    cyc(); cyc(); cyc(); cyc();
    chk("bb_c5_ready", ready0, 0);
    cyc();
    chk("bb_c6_ready", ready0, 1);
    w_en = 1'b0; r_en = 1'b1;
    cyc();
    chk("bb_c7_ready", ready0, 0);
    cyc();
    chk("bb_c8_addr", saddr0, 0);
    chk("bb_c8_we_n", wen0, 1);
    cyc(); cyc(); cyc(); cyc();
    chk("bb_c12_ready", ready0, 0);
    cyc();
    chk("bb_c13_ready", ready0, 1);
    chk("bb_c13_rdata", rdata0, 32'hCAFEF00D);
    r_en = 1'b0;
    cyc();

    // Both enables high: write wins
    addr = 32'd1032; wdata = 32'h0BADC0DE; w_en = 1'b1; r_en = 1'b1;
    cyc();
    chk("both_c1_we_n", wen0, 0);
    chk("both_c1_addr", saddr0, 4);
    chk("both_c1_dq", dqo0, 32'hC0DE);
    cyc();
    chk("both_c2_we_n", wen0, 0);
    chk("both_c2_addr", saddr0, 5);
    chk("both_c2_dq", dqo0, 32'h0BAD);
    cyc(); cyc(); cyc(); cyc();
    chk("both_c6_ready", ready0, 1);
    chk("both_c6_rdata", rdata0, 32'hCAFEF00D);
    w_en = 1'b0;
    cyc();
    chk("both_after_ready", ready0, 0);
    cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
    chk("both_ld_ready", ready0, 1);
    chk("both_ld_rdata", rdata0, 32'h0BADC0DE);
    r_en = 1'b0;
    cyc();

    // Zero wait cycles: DONE in cycle 3
    addr = 32'd1028; r1_en = 1'b1;
    #1 chk("w0_c0_ready", ready1, 0);
    cyc();
    chk("w0_c1_addr", saddr1, 2);
    chk("w0_c1_ready", ready1, 0);
    cyc();
    chk("w0_c2_addr", saddr1, 3);
    chk("w0_c2_ready", ready1, 0);
    cyc();
    chk("w0_c3_ready", ready1, 1);
    chk("w0_c3_rdata", rdata1, 32'hA5C3A5C3);
    r1_en = 1'b0;
    cyc();
    chk("w0_idle_ready", ready1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
